// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the peripheral bus (LEDS, UART, SD card) between two masters.
// Define IO_ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed M0 priority.
module io_bus_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            REQ,
    input  logic [1:0]            WE,
    input  logic [2*ADDR_W-1:0]   A,
    input  logic [2*DATA_W-1:0]   WD,
    output logic [1:0]            ACK,
    output logic [DATA_W-1:0]     RD,
    output logic                  ERR,
    output logic [2:0]            P_WE,
    output logic [2:0]            P_RE,
    output logic [ADDR_W-3:0]     P_A,
    output logic [DATA_W-1:0]     P_WD,
    input  logic [DATA_W-1:0]     P_RD_LEDS,
    input  logic [DATA_W-1:0]     P_RD_UART,
    input  logic [DATA_W-1:0]     P_RD_SD
);

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StResp
    } state_e;

    localparam logic [1:0] SelUnmapped = 2'b11;

    state_e            state;
    logic              win_m1;
    logic              wr;
    logic [1:0]        sel;

    logic              grant_m1;
    logic [ADDR_W-1:0] req_a;
    logic [DATA_W-1:0] req_wd;
    logic              req_we;
    logic [1:0]        req_sel;
    logic [2:0]        req_strobe;
    logic [DATA_W-1:0] rd_mux;

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On contention the master that did not win last time goes next.
    always_comb begin
        grant_m1 = ~REQ[0];
        if (REQ == 2'b11) begin
            grant_m1 = ~last_grant;
        end
    end
`else
    always_comb begin
        grant_m1 = ~REQ[0];
    end
`endif

    always_comb begin
        req_a      = grant_m1 ? A[2*ADDR_W-1:ADDR_W] : A[ADDR_W-1:0];
        req_wd     = grant_m1 ? WD[2*DATA_W-1:DATA_W] : WD[DATA_W-1:0];
        req_we     = grant_m1 ? WE[1] : WE[0];
        req_sel    = req_a[ADDR_W-1:ADDR_W-2];
        req_strobe = (req_sel == SelUnmapped) ? 3'b000 : (3'b001 << req_sel);
    end

    always_comb begin
        case (sel)
            2'b00:   rd_mux = P_RD_LEDS;
            2'b01:   rd_mux = P_RD_UART;
            2'b10:   rd_mux = P_RD_SD;
            default: rd_mux = '0;
        endcase
    end

    // Strobes are registered at grant so they are high for exactly the STROBE cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= StIdle;
            ACK    <= 2'b00;
            ERR    <= 1'b0;
            RD     <= '0;
            P_WE   <= 3'b000;
            P_RE   <= 3'b000;
            P_A    <= '0;
            P_WD   <= '0;
            win_m1 <= 1'b0;
            wr     <= 1'b0;
            sel    <= 2'b00;
`ifdef IO_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (REQ != 2'b00) begin
                        win_m1 <= grant_m1;
                        wr     <= req_we;
                        sel    <= req_sel;
                        P_A    <= req_a[ADDR_W-3:0];
                        P_WD   <= req_wd;
                        P_WE   <= req_we ? req_strobe : 3'b000;
                        P_RE   <= req_we ? 3'b000 : req_strobe;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        last_grant <= grant_m1;
`endif
                        state  <= StStrobe;
                    end
                end
                StStrobe: begin
                    P_WE  <= 3'b000;
                    P_RE  <= 3'b000;
                    RD    <= wr ? '0 : rd_mux;
                    ACK   <= win_m1 ? 2'b10 : 2'b01;
                    ERR   <= (sel == SelUnmapped);
                    state <= StResp;
                end
                StResp: begin
                    ACK   <= 2'b00;
                    ERR   <= 1'b0;
                    RD    <= '0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // Bus-protocol invariants
    assert property (@(posedge CLK) $onehot0({P_WE, P_RE}));
    assert property (@(posedge CLK) (state != StStrobe) |-> ({P_WE, P_RE} == 6'b0));
    assert property (@(posedge CLK) $onehot0(ACK));

endmodule
